// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory arbiter slice.
// Pure declarations; no logic, no state.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_IO_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_IF = 2'd0,
    OWN_LD = 2'd1,
    OWN_ST = 2'd2
  } owner_t;

  localparam logic [1:0] IO_HI = 2'b11;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  // Narrow loads come back zero-extended; odd sizes pass the word through untouched.
  function automatic logic [31:0] zext_load(input logic [31:0] d, input logic [2:0] sz);
    case (sz)
      SZ_B:    return {24'h0, d[7:0]};
      SZ_H:    return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for IF/load/store: starved IF first, then store, load, IF.
// Combinational, zero latency; io_hold flags a store that must wait on the UART buffer.
module mem_arb_pick #(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [1:0] IO_HI        = mem_pkg::IO_HI,
  parameter int         CW           = 3
) (
  input  logic          if_req,
  input  logic          ld_req,
  input  logic          st_req,
  input  logic [1:0]    st_region,
  input  logic          io_buffer_full,
  input  logic [CW-1:0] starve_cnt,
  output logic [2:0]    gnt,
  output logic          io_hold
);

  // gnt bit order: [0]=IF, [1]=load, [2]=store
  always_comb begin
    gnt = 3'b000;
    if (if_req && (starve_cnt == CW'(STARVE_LIMIT))) begin
      gnt[0] = 1'b1;
    end else if (st_req) begin
      gnt[2] = 1'b1;
    end else if (ld_req) begin
      gnt[1] = 1'b1;
    end else if (if_req) begin
      gnt[0] = 1'b1;
    end
  end

  assign io_hold = gnt[2] && (st_region == IO_HI) && io_buffer_full;

endmodule

// File: rtl/mem_arbiter.sv
// Single-owner scheduler for IF/load/store in front of the byte-serial memory controller.
// Grant to mc_valid 1 cycle, done pulse 1 cycle after mc_done; rdy=0 freezes, IO stores wait in IO_WAIT.
module mem_arbiter #(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [1:0] IO_HI        = mem_pkg::IO_HI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_rst,
  input  logic        io_buffer_full,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_size,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_wdata,
  output logic        st_done,
  output logic        mc_valid,
  output logic        mc_write,
  output logic [31:0] mc_addr,
  output logic [2:0]  mc_size,
  output logic [31:0] mc_wdata,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);
  import mem_pkg::*;

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  state_t        state_q, state_d;
  owner_t        owner_q, win_own;
  logic [CW-1:0] starve_q;
  logic          discard_q;
  logic [2:0]    gnt;
  logic          io_hold;
  logic          grant;
  logic          flush_spec;
  logic [31:0]   win_addr;
  logic [2:0]    win_size;
  logic [31:0]   win_wdata;

  // A flush blocks speculative IF/load grants in the same cycle; committed stores still go.
  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .IO_HI        (IO_HI),
    .CW           (CW)
  ) u_pick (
    .if_req         (if_valid && !jump_rst),
    .ld_req         (ld_valid && !jump_rst),
    .st_req         (st_valid),
    .st_region      (st_addr[17:16]),
    .io_buffer_full (io_buffer_full),
    .starve_cnt     (starve_q),
    .gnt            (gnt),
    .io_hold        (io_hold)
  );

  assign grant      = (state_q == ST_IDLE) && (gnt != 3'b000);
  assign flush_spec = jump_rst && (owner_q != OWN_ST);

  always_comb begin
    win_own   = OWN_IF;
    win_addr  = if_addr;
    win_size  = SZ_W;
    win_wdata = 32'h0;
    if (gnt[2]) begin
      win_own   = OWN_ST;
      win_addr  = st_addr;
      win_size  = st_size;
      win_wdata = st_wdata;
    end else if (gnt[1]) begin
      win_own   = OWN_LD;
      win_addr  = ld_addr;
      win_size  = ld_size;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) state_d = io_hold ? ST_IO_WAIT : ST_ISSUE;
      end
      ST_IO_WAIT: begin
        if (flush_spec)           state_d = ST_IDLE;
        else if (!io_buffer_full) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (mc_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      starve_q  <= '0;
      discard_q <= 1'b0;
      mc_valid  <= 1'b0;
      mc_write  <= 1'b0;
      mc_addr   <= 32'h0;
      mc_size   <= 3'd0;
      mc_wdata  <= 32'h0;
      if_done   <= 1'b0;
      if_data   <= 32'h0;
      ld_done   <= 1'b0;
      ld_data   <= 32'h0;
      st_done   <= 1'b0;
    end else if (!rdy) begin
      if_done <= 1'b0;
      ld_done <= 1'b0;
      st_done <= 1'b0;
    end else begin
      state_q <= state_d;
      if_done <= 1'b0;
      ld_done <= 1'b0;
      st_done <= 1'b0;

      if (jump_rst) begin
        starve_q <= '0;
      end else if (grant) begin
        if (gnt[0])                                          starve_q <= '0;
        else if (if_valid && (starve_q != CW'(STARVE_LIMIT))) starve_q <= starve_q + CW'(1);
      end

      // Requester fields are captured once here and never re-read until completion.
      if (grant) begin
        owner_q  <= win_own;
        mc_write <= gnt[2];
        mc_addr  <= win_addr;
        mc_size  <= win_size;
        mc_wdata <= win_wdata;
        mc_valid <= !io_hold;
      end

      if ((state_q == ST_IO_WAIT) && (state_d == ST_ISSUE)) mc_valid <= 1'b1;

      if (state_q == ST_ISSUE) begin
        if (flush_spec) discard_q <= 1'b1;
        if (mc_done) begin
          mc_valid  <= 1'b0;
          discard_q <= 1'b0;
          if (!(discard_q || flush_spec)) begin
            case (owner_q)
              OWN_IF: begin
                if_done <= 1'b1;
                if_data <= mc_rdata;
              end
              OWN_LD: begin
                ld_done <= 1'b1;
                ld_data <= zext_load(mc_rdata, mc_size);
              end
              default: st_done <= 1'b1;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, behavioural controller, decoupled monitor.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        jump_rst;
  logic        io_buffer_full;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_size;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [2:0]  st_size;
  logic [31:0] st_wdata;
  logic        st_done;
  logic        mc_valid;
  logic        mc_write;
  logic [31:0] mc_addr;
  logic [2:0]  mc_size;
  logic [31:0] mc_wdata;
  logic        mc_done;
  logic [31:0] mc_rdata;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_rst(jump_rst), .io_buffer_full(io_buffer_full),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_done(ld_done), .ld_data(ld_data),
    .st_valid(st_valid), .st_addr(st_addr), .st_size(st_size), .st_wdata(st_wdata), .st_done(st_done),
    .mc_valid(mc_valid), .mc_write(mc_write), .mc_addr(mc_addr), .mc_size(mc_size),
    .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int O_IF = 0;
  localparam int O_LD = 1;
  localparam int O_ST = 2;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          owner;
    logic [31:0] data;
    bit          discard;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   hold_req = 0;
  int   lat = 2;
  logic [31:0] mem [logic [31:0]];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void push_req(logic [31:0] a, logic w, logic [2:0] s, logic [31:0] d);
    req_t r;
    r.addr = a; r.write = w; r.size = s; r.wdata = d;
    req_q.push_back(r);
  endfunction

  function automatic void push_rsp(int o, logic [31:0] d, bit disc);
    rsp_t r;
    r.owner = o; r.data = d; r.discard = disc;
    rsp_q.push_back(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while ((if_valid || ld_valid || st_valid || mc_valid) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout after %0d cycles, transaction still pending", name, limit);
      if_valid = 0; ld_valid = 0; st_valid = 0;
    end
    step();
  endtask

  task automatic wait_issue(input int limit, input string name);
    int n = 0;
    while (!mc_valid && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: mc_valid never rose within %0d cycles", name, limit);
    end
  endtask

  // Behavioural byte-serial controller: fixed latency, word-sized backing store.
  initial begin
    int cnt;
    cnt = 0;
    mc_done = 1'b0;
    mc_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mc_done = 1'b0;
        cnt = 0;
      end else if (mc_done) begin
        mc_done = 1'b0;
        cnt = 0;
      end else if (mc_valid) begin
        if (cnt >= lat) begin
          mc_done = 1'b1;
          cnt = 0;
          if (mc_write) mem[mc_addr] = mc_wdata;
          else mc_rdata = mem.exists(mc_addr) ? mem[mc_addr] : (mc_addr ^ 32'h5A5A0000);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Requesters release their request once they see their own done pulse.
  initial begin
    forever begin
      step();
      if (!hold_req) begin
        if (if_done) if_valid = 1'b0;
        if (ld_done) ld_valid = 1'b0;
        if (st_done) st_valid = 1'b0;
      end
    end
  end

  // Monitor: checks each new downstream request and the cycle after each mc_done.
  initial begin
    logic prev_v;
    req_t r;
    rsp_t s;
    logic [2:0] exp_oh;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        prev_v = 1'b0;
      end else begin
        if (mc_valid && !prev_v) begin
          if (req_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_issue: got addr 0x%08h, required no request", mc_addr);
          end else begin
            r = req_q.pop_front();
            chk("mc_addr", mc_addr, r.addr);
            chk("mc_write", 32'(mc_write), 32'(r.write));
            chk("mc_size", 32'(mc_size), 32'(r.size));
            if (r.write) chk("mc_wdata", mc_wdata, r.wdata);
          end
        end
        if (mc_done) begin
          if (rsp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_completion: got mc_done with no pending response");
          end else begin
            s = rsp_q.pop_front();
            if (s.discard) begin
              chk("flushed_no_done", 32'({if_done, ld_done, st_done}), 32'h0);
            end else begin
              exp_oh = (s.owner == O_IF) ? 3'b100 : (s.owner == O_LD) ? 3'b010 : 3'b001;
              chk("done_owner", 32'({if_done, ld_done, st_done}), 32'(exp_oh));
              if (s.owner == O_IF) chk("if_data", if_data, s.data);
              if (s.owner == O_LD) chk("ld_data", ld_data, s.data);
            end
          end
        end else if (if_done || ld_done || st_done) begin
          vectors++;
          miscompares++;
          $display("FAIL stray_done: got done pulses %b without preceding mc_done",
                   {if_done, ld_done, st_done});
        end
        prev_v = mc_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; rdy = 1; jump_rst = 0; io_buffer_full = 0;
    if_valid = 0; if_addr = 0;
    ld_valid = 0; ld_addr = 0; ld_size = 0;
    st_valid = 0; st_addr = 0; st_size = 0; st_wdata = 0;
    mem[32'h100] = 32'h00500093;

    repeat (3) step();
    chk("rst_mc_valid", 32'(mc_valid), 32'h0);
    chk("rst_mc_addr", mc_addr, 32'h0);
    chk("rst_mc_size", 32'(mc_size), 32'h0);
    chk("rst_dones", 32'({if_done, ld_done, st_done}), 32'h0);
    chk("rst_data", if_data | ld_data, 32'h0);
    rst = 1;

    // Plain instruction fetch right after reset.
    push_req(32'h100, 1'b0, 3'd4, 32'h0);
    push_rsp(O_IF, 32'h00500093, 0);
    if_valid = 1; if_addr = 32'h100;
    wait_idle(100, "if_fetch");

    // Three requesters at once: store, then load, then IF.
    push_req(32'h2000, 1'b1, 3'd4, 32'hDEADBEEF);
    push_rsp(O_ST, 32'h0, 0);
    push_req(32'h2000, 1'b0, 3'd1, 32'h0);
    push_rsp(O_LD, 32'h000000EF, 0);
    push_req(32'h104, 1'b0, 3'd4, 32'h0);
    push_rsp(O_IF, 32'h5A5A0104, 0);
    st_valid = 1; st_addr = 32'h2000; st_size = 3'd4; st_wdata = 32'hDEADBEEF;
    ld_valid = 1; ld_addr = 32'h2000; ld_size = 3'd1;
    if_valid = 1; if_addr = 32'h104;
    wait_idle(200, "priority_order");

    // Starvation: four store wins with IF waiting, fifth grant goes to IF.
    for (int i = 0; i < 4; i++) begin
      push_req(32'h3000, 1'b1, 3'd4, 32'h11223344);
      push_rsp(O_ST, 32'h0, 0);
    end
    push_req(32'h200, 1'b0, 3'd4, 32'h0);
    push_rsp(O_IF, 32'h5A5A0200, 0);
    hold_req = 1;
    st_valid = 1; st_addr = 32'h3000; st_size = 3'd4; st_wdata = 32'h11223344;
    ld_valid = 1; ld_addr = 32'h3000; ld_size = 3'd4;
    if_valid = 1; if_addr = 32'h200;
    begin
      int n = 0;
      while (!if_done && n < 300) begin
        step();
        n++;
      end
      if (n >= 300) begin
        vectors++;
        miscompares++;
        $display("FAIL starve_if: if_done not seen within 300 cycles");
      end
    end
    st_valid = 0; ld_valid = 0; if_valid = 0;
    hold_req = 0;
    wait_idle(100, "starve_drain");

    // UART window store held while the io buffer is full.
    io_buffer_full = 1;
    push_req(32'h30000, 1'b1, 3'd1, 32'h41);
    push_rsp(O_ST, 32'h0, 0);
    st_valid = 1; st_addr = 32'h30000; st_size = 3'd1; st_wdata = 32'h41;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("io_wait_hold", 32'(mc_valid), 32'h0);
    end
    io_buffer_full = 0;
    step();
    chk("io_issue", 32'(mc_valid), 32'h1);
    wait_idle(100, "io_store");

    // Flush during a load: completion consumed, no ld_done.
    push_req(32'h40, 1'b0, 3'd4, 32'h0);
    push_rsp(O_LD, 32'h0, 1);
    ld_valid = 1; ld_addr = 32'h40; ld_size = 3'd4;
    wait_issue(50, "flush_ld_issue");
    jump_rst = 1; ld_valid = 0;
    step();
    jump_rst = 0;
    wait_idle(100, "flush_ld");

    push_req(32'h100, 1'b0, 3'd4, 32'h0);
    push_rsp(O_IF, 32'h00500093, 0);
    if_valid = 1; if_addr = 32'h100;
    wait_idle(100, "post_flush_if");

    // Flush during a store: stores are committed, st_done still fires.
    push_req(32'h80, 1'b1, 3'd2, 32'h0000CAFE);
    push_rsp(O_ST, 32'h0, 0);
    st_valid = 1; st_addr = 32'h80; st_size = 3'd2; st_wdata = 32'h0000CAFE;
    wait_issue(50, "flush_st_issue");
    jump_rst = 1;
    step();
    jump_rst = 0;
    wait_idle(100, "flush_st");

    // Global stall mid-transaction.
    lat = 8;
    push_req(32'h2000, 1'b0, 3'd2, 32'h0);
    push_rsp(O_LD, 32'h0000BEEF, 0);
    ld_valid = 1; ld_addr = 32'h2000; ld_size = 3'd2;
    wait_issue(50, "rdy_issue");
    step();
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_mc_valid", 32'(mc_valid), 32'h1);
      chk("stall_mc_addr", mc_addr, 32'h2000);
      chk("stall_ld_done", 32'(ld_done), 32'h0);
    end
    rdy = 1;
    wait_idle(100, "rdy_stall");
    lat = 2;

    // Asynchronous reset in the middle of a transaction.
    push_req(32'h44, 1'b0, 3'd4, 32'h0);
    ld_valid = 1; ld_addr = 32'h44; ld_size = 3'd4;
    wait_issue(50, "arst_issue");
    #3;
    rst = 0;
    #1;
    chk("arst_mc_valid", 32'(mc_valid), 32'h0);
    chk("arst_mc_addr", mc_addr, 32'h0);
    ld_valid = 0;
    step();
    step();
    rst = 1;
    repeat (3) step();
    chk("arst_idle_mc_valid", 32'(mc_valid), 32'h0);

    chk("req_queue_drained", 32'(req_q.size()), 32'h0);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
